// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mac_pkg
// Brief   : Shared FSM encodings and default widths for mac_acc and its bench.
// Rev     : 1.0  initial release
// ============================================================================
package mac_pkg;

  localparam int MAC_WIDTH = 6;
  localparam int MAC_ACC_W = 16;
  localparam int MAC_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_top.sv
`default_nettype none
// ============================================================================
// Module  : mul_top
// Brief   : Combinational signed multiplier, product modulo 2^(2*WIDTH).
// Rev     : 1.0  initial release
// ============================================================================
module mul_top #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] out
);

  logic signed [2*WIDTH-1:0] w_a_ext;
  logic signed [2*WIDTH-1:0] w_b_ext;

  assign w_a_ext = (2*WIDTH)'($signed(a));
  assign w_b_ext = (2*WIDTH)'($signed(b));
  assign out     = w_a_ext * w_b_ext;

endmodule
`default_nettype wire

// File: rtl/mac_acc.sv
`default_nettype none
// ============================================================================
// Module  : mac_acc
// Brief   : Two-stage multiply-accumulate producing one dot product per vector.
// Rev     : 1.0  initial release
// ============================================================================
module mac_acc
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH,
  parameter int ACC_W = MAC_ACC_W,
  parameter int CNT_W = MAC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  state_t r_state;
  state_t w_state_nxt;

  logic               r_s1_vld;
  logic               r_s1_last;
  logic [WIDTH-1:0]   r_s1_a;
  logic [WIDTH-1:0]   r_s1_b;
  logic               r_s2_vld;
  logic               r_s2_last;
  logic [2*WIDTH-1:0] r_s2_prod;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;

  logic               w_ready;
  logic               w_accept;
  logic               w_clear;
  logic [2*WIDTH-1:0] w_prod;
  logic [ACC_W-1:0]   w_addend;
  logic [ACC_W-1:0]   w_sum;
  logic               w_ovf;

  mul_top #(
    .WIDTH (WIDTH)
  ) u_mul (
    .a   (r_s1_a),
    .b   (r_s1_b),
    .out (w_prod)
  );

  // Reset is folded in so the stage never advertises ready while held in reset.
  assign in_ready = w_ready & rst_n;
  assign w_accept = in_valid & in_ready;
  assign w_clear  = (r_state == ST_HOLD) & out_ready;

  assign w_addend = ACC_W'($signed(r_s2_prod));
  assign w_sum    = r_acc + w_addend;
  assign w_ovf    = (r_acc[ACC_W-1] == w_addend[ACC_W-1]) &&
                    (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        w_ready = 1'b1;
        if (w_accept && in_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_s2_vld && r_s2_last) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_ACCUM;
        end
      end
      default: begin
        w_state_nxt = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_prod <= '0;
    end else begin
      r_s1_vld  <= w_accept;
      if (w_accept) begin
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
        r_s1_last <= in_last;
      end
      r_s2_vld  <= r_s1_vld;
      r_s2_last <= r_s1_vld & r_s1_last;
      r_s2_prod <= w_prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (r_s2_vld) begin
        r_acc <= w_sum;
        r_ovf <= r_ovf | w_ovf;
      end
      if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out_acc = r_acc;
  assign out_cnt = r_cnt;
  assign out_ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mac_acc.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_acc
// Brief   : Scoreboard bench for mac_acc; model sums pushed at stimulus time.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mac_acc;
  import mac_pkg::*;

  localparam int WIDTH = MAC_WIDTH;
  localparam int ACC_W = MAC_ACC_W;
  localparam int CNT_W = MAC_CNT_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  always #5 clk = ~clk;

  mac_acc #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } res_t;

  res_t sb_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_results = 0;

  logic signed [ACC_W-1:0] m_acc;
  logic [CNT_W-1:0]        m_cnt;
  logic                    m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_acc = '0;
    m_cnt = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_add(input int a, input int b);
    logic signed [ACC_W-1:0] p;
    logic signed [ACC_W-1:0] s;
    p = ACC_W'(a * b);
    s = m_acc + p;
    if ((m_acc[ACC_W-1] == p[ACC_W-1]) && (s[ACC_W-1] != m_acc[ACC_W-1])) m_ovf = 1'b1;
    m_acc = s;
    m_cnt = m_cnt + CNT_W'(1);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_beat(input int a, input int b, input bit last);
    int   w;
    res_t r;
    in_valid = 1'b1;
    in_a     = a[WIDTH-1:0];
    in_b     = b[WIDTH-1:0];
    in_last  = last;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_add(a, b);
    if (last) begin
      r.acc = m_acc;
      r.cnt = m_cnt;
      r.ovf = m_ovf;
      sb_q.push_back(r);
      model_clear();
    end
  endtask

  task automatic wait_out();
    int w;
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  always @(negedge clk) begin
    res_t r;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        r = sb_q.pop_front();
        chk("sb_acc", 32'(out_acc), 32'(r.acc));
        chk("sb_cnt", 32'(out_cnt), 32'(r.cnt));
        chk("sb_ovf", 32'(out_ovf), 32'(r.ovf));
        n_results++;
      end
    end
  end

  initial begin
    logic [ACC_W-1:0] snap_acc;
    logic [CNT_W-1:0] snap_cnt;
    logic             snap_ovf;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    model_clear();

    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_acc",   32'(out_acc),   32'd0);
    chk("rst_out_cnt",   32'(out_cnt),   32'd0);
    chk("rst_out_ovf",   32'(out_ovf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Single beat: result visible two edges after acceptance, for one cycle.
    send_beat(3, -5, 1'b1);
    chk("t1_ready_drop", 32'(in_ready),  32'd0);
    chk("t1_lat_k",      32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_lat_k1",     32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_lat_k2",     32'(out_valid), 32'd1);
    chk("t1_acc",        32'(out_acc),   32'(16'hFFF1));
    chk("t1_cnt",        32'(out_cnt),   32'd1);
    chk("t1_ovf",        32'(out_ovf),   32'd0);
    @(posedge clk); #1;
    chk("t1_one_cycle",  32'(out_valid), 32'd0);
    chk("t1_ready_back", 32'(in_ready),  32'd1);

    // Back-to-back vector.
    send_beat(1, 2, 1'b0);
    send_beat(-3, 4, 1'b0);
    send_beat(31, 31, 1'b0);
    send_beat(-32, -32, 1'b1);
    wait_out();
    chk("t2_acc", 32'(out_acc), 32'd1975);
    chk("t2_cnt", 32'(out_cnt), 32'd4);
    @(posedge clk); #1;
    chk("t2_one_cycle", 32'(out_valid), 32'd0);

    // Accumulator wrap and sticky overflow, then cleared by the handshake.
    for (int i = 0; i < 32; i++) send_beat(-32, -32, i == 31);
    wait_out();
    chk("t3_acc", 32'(out_acc), 32'(16'h8000));
    chk("t3_ovf", 32'(out_ovf), 32'd1);
    @(posedge clk); #1;
    send_beat(1, 1, 1'b1);
    wait_out();
    chk("t3b_acc", 32'(out_acc), 32'd1);
    chk("t3b_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk); #1;

    // Backpressure in HOLD with offered beats that must be ignored.
    out_ready = 1'b0;
    send_beat(5, 6, 1'b0);
    send_beat(-2, 3, 1'b1);
    wait_out();
    snap_acc = out_acc;
    snap_cnt = out_cnt;
    snap_ovf = out_ovf;
    chk("t4_acc", 32'(out_acc), 32'd24);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_a     = WIDTH'($urandom);
      in_b     = WIDTH'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
      chk("t4_ready_low", 32'(in_ready),  32'd0);
      chk("t4_valid_hi",  32'(out_valid), 32'd1);
      chk("t4_acc_hold",  32'(out_acc),   32'(snap_acc));
      chk("t4_cnt_hold",  32'(out_cnt),   32'(snap_cnt));
      chk("t4_ovf_hold",  32'(out_ovf),   32'(snap_ovf));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send_beat(7, 1, 1'b1);
    wait_out();
    chk("t4b_acc", 32'(out_acc), 32'd7);
    chk("t4b_cnt", 32'(out_cnt), 32'd1);
    @(posedge clk); #1;

    // Gappy input stream.
    for (int i = 0; i < 5; i++) begin
      send_beat(-1, -1, i == 4);
      @(posedge clk); #1;
    end
    wait_out();
    chk("t5_acc", 32'(out_acc), 32'd5);
    chk("t5_cnt", 32'(out_cnt), 32'd5);
    @(posedge clk); #1;

    // Asynchronous reset mid-vector discards the partial sum.
    for (int i = 0; i < 3; i++) send_beat(9, 3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("t6_rst_ready", 32'(in_ready),  32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_acc",   32'(out_acc),   32'd0);
    chk("t6_rst_cnt",   32'(out_cnt),   32'd0);
    chk("t6_rst_ovf",   32'(out_ovf),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_acc_after_rst", 32'(out_acc), 32'd0);
    send_beat(2, 2, 1'b0);
    send_beat(2, 2, 1'b1);
    wait_out();
    chk("t6_acc", 32'(out_acc), 32'd8);
    chk("t6_cnt", 32'(out_cnt), 32'd2);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty",   32'(sb_q.size()), 32'd0);
    chk("n_results",  32'(n_results),   32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
